mem_wait_wrapped: RTL and testbench

MEM_WAIT_WRAPPED -- requirements
Module: mem_wait_wrapped

---
 rtl/mem_pkg.sv | 65 ++++++
 rtl/mem_port_fsm.sv | 118 +++++++++++
 rtl/mem_wait_wrapped.sv | 148 ++++++++++++++
 tb/tb_mem_wait_wrapped.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types, widths and lane/alignment helpers for the wait-state memory.
package mem_pkg;

  localparam int WORD_W = 32;

  // Transfer size encoding on the data bus; code 3 is reserved and illegal.
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } tsize_t;

  // Per-port transaction sequencing.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } port_state_t;

  // Byte-lane enables for a transfer of the given size at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [1:0] tsize, input logic [1:0] off);
    logic [3:0] mask;
    case (tsize)
      BYTE:    mask = 4'b0001 << off;
      HALF:    mask = off[1] ? 4'b1100 : 4'b0011;
      WORD:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Misalignment or illegal size; the range check is done by the caller.
  function automatic logic align_err(input logic [1:0] tsize, input logic [1:0] off);
    logic bad;
    case (tsize)
      BYTE:    bad = 1'b0;
      HALF:    bad = off[0];
      WORD:    bad = (off != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Move right-justified write data up onto its byte lanes.
  function automatic logic [WORD_W-1:0] wr_align(input logic [WORD_W-1:0] wdata,
                                                 input logic [1:0] off);
    return wdata << {off, 3'b000};
  endfunction

  // Pull the addressed bytes out of a word, right-justified and zero-extended.
  function automatic logic [WORD_W-1:0] rd_extract(input logic [WORD_W-1:0] word,
                                                   input logic [1:0] tsize,
                                                   input logic [1:0] off);
    logic [WORD_W-1:0] sh;
    logic [WORD_W-1:0] res;
    sh = word >> {off, 3'b000};
    case (tsize)
      BYTE:    res = {24'd0, sh[7:0]};
      HALF:    res = {16'd0, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// Per-port request sequencer: captures a request, counts wait states, then
// raises an access strobe on the edge entering DONE and a one-cycle done.
// Every transaction passes through WAIT (even with zero wait states) so the
// req-to-done latency is WAIT+2 edges and back-to-back requests recur every
// WAIT+3 cycles.
module mem_port_fsm
  import mem_pkg::port_state_t;
  import mem_pkg::IDLE;
  import mem_pkg::DONE;
#(
  parameter int WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_tsize,
  input  logic        i_write,
  input  logic [31:0] i_wdata,
  output logic        o_acc,
  output logic        o_done,
  output logic [31:0] o_addr,
  output logic [1:0]  o_tsize,
  output logic        o_write,
  output logic [31:0] o_wdata
);

  localparam logic [3:0] WAIT_C = 4'(WAIT);

  port_state_t r_state;
  port_state_t w_next;
  logic        w_enter_done;
  logic [3:0]  r_cnt;
  logic        r_done;
  logic [31:0] r_addr;
  logic [1:0]  r_tsize;
  logic        r_write;
  logic [31:0] r_wdata;

  // Next-state decode; the access happens on the WAIT->DONE transition.
  always_comb begin
    w_next       = r_state;
    w_enter_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req) begin
          w_next = mem_pkg::WAIT;
        end else begin
          w_next = IDLE;
        end
      end
      mem_pkg::WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next       = DONE;
          w_enter_done = 1'b1;
        end else begin
          w_next = mem_pkg::WAIT;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Reset on the same edge cancels the access so an aborted write never lands.
  assign o_acc = w_enter_done & ~rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait-state counter: loaded at capture, counts down to zero in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 4'd0;
    end else if (r_state == IDLE && i_req) begin
      r_cnt <= WAIT_C;
    end else if (r_state == mem_pkg::WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Registered done pulse, high for the single cycle spent in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_enter_done;
    end
  end

  // Request capture; later input changes are ignored until the next IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= 32'd0;
      r_tsize <= 2'd0;
      r_write <= 1'b0;
      r_wdata <= 32'd0;
    end else if (r_state == IDLE && i_req) begin
      r_addr  <= i_addr;
      r_tsize <= i_tsize;
      r_write <= i_write;
      r_wdata <= i_wdata;
    end
  end

  assign o_done  = r_done;
  assign o_addr  = r_addr;
  assign o_tsize = r_tsize;
  assign o_write = r_write;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/mem_wait_wrapped.sv
// Single-clock word memory with a read-only instruction port and a
// byte/half/word data port, each with its own fixed wait-state count.
// One write port (dbus) and two read ports; reads see pre-edge contents,
// so an ibus read colliding with a dbus write returns the old word.
module mem_wait_wrapped
  import mem_pkg::*;
#(
  parameter int N     = 1024,
  parameter int IWAIT = 0,
  parameter int DWAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ibus_req,
  input  logic [31:0] ibus_addr,
  output logic [31:0] ibus_rdata,
  output logic        ibus_done,
  output logic        ibus_err,
  input  logic        dbus_req,
  input  logic        dbus_write,
  input  logic [1:0]  dbus_tsize,
  input  logic [31:0] dbus_addr,
  input  logic [31:0] dbus_wdata,
  output logic [31:0] dbus_rdata,
  output logic        dbus_done,
  output logic        dbus_err
);

  localparam int AW = $clog2(N);

  logic [WORD_W-1:0] r_mem [N];

  logic              w_i_acc;
  logic              w_i_done;
  logic [31:0]       w_i_addr;
  logic [1:0]        w_i_tsize;
  logic              w_i_write;
  logic [31:0]       w_i_wdata;
  logic [AW-1:0]     w_i_idx;
  logic [1:0]        w_i_off;
  logic              w_i_err;
  logic              w_ibus_unused;

  logic              w_d_acc;
  logic              w_d_done;
  logic [31:0]       w_d_addr;
  logic [1:0]        w_d_tsize;
  logic              w_d_write;
  logic [31:0]       w_d_wdata;
  logic [AW-1:0]     w_d_idx;
  logic [1:0]        w_d_off;
  logic              w_d_err;
  logic [3:0]        w_d_be;
  logic [WORD_W-1:0] w_d_wd;

  logic [WORD_W-1:0] r_irdata;
  logic              r_ierr;
  logic [WORD_W-1:0] r_drdata;
  logic              r_derr;

  mem_port_fsm #(.WAIT(IWAIT)) u_ibus_fsm (
    .clk     (clk),
    .rst     (rst),
    .i_req   (ibus_req),
    .i_addr  (ibus_addr),
    .i_tsize (WORD),
    .i_write (1'b0),
    .i_wdata (32'd0),
    .o_acc   (w_i_acc),
    .o_done  (w_i_done),
    .o_addr  (w_i_addr),
    .o_tsize (w_i_tsize),
    .o_write (w_i_write),
    .o_wdata (w_i_wdata)
  );

  mem_port_fsm #(.WAIT(DWAIT)) u_dbus_fsm (
    .clk     (clk),
    .rst     (rst),
    .i_req   (dbus_req),
    .i_addr  (dbus_addr),
    .i_tsize (dbus_tsize),
    .i_write (dbus_write),
    .i_wdata (dbus_wdata),
    .o_acc   (w_d_acc),
    .o_done  (w_d_done),
    .o_addr  (w_d_addr),
    .o_tsize (w_d_tsize),
    .o_write (w_d_write),
    .o_wdata (w_d_wdata)
  );

  // The instruction port is read-only; its write fields are tied off.
  assign w_ibus_unused = w_i_write ^ (^w_i_wdata);

  // Address decode and error detection for both ports.
  assign w_i_idx = w_i_addr[AW+1:2];
  assign w_i_off = w_i_addr[1:0];
  assign w_i_err = (|w_i_addr[WORD_W-1:AW+2]) | align_err(w_i_tsize, w_i_off);

  assign w_d_idx = w_d_addr[AW+1:2];
  assign w_d_off = w_d_addr[1:0];
  assign w_d_err = (|w_d_addr[WORD_W-1:AW+2]) | align_err(w_d_tsize, w_d_off);
  assign w_d_be  = lane_mask(w_d_tsize, w_d_off);
  assign w_d_wd  = wr_align(w_d_wdata, w_d_off);

  // Storage write port: lane-masked, only for error-free dbus writes.
  always_ff @(posedge clk) begin
    if (w_d_acc && w_d_write && !w_d_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_d_be[i]) begin
          r_mem[w_d_idx][8*i +: 8] <= w_d_wd[8*i +: 8];
        end
      end
    end
  end

  // ibus read data and error, registered on DONE entry and held afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irdata <= 32'd0;
      r_ierr   <= 1'b0;
    end else if (w_i_acc) begin
      r_ierr   <= w_i_err;
      r_irdata <= w_i_err ? 32'd0 : rd_extract(r_mem[w_i_idx], w_i_tsize, w_i_off);
    end
  end

  // dbus read data and error; writes and errored accesses return zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drdata <= 32'd0;
      r_derr   <= 1'b0;
    end else if (w_d_acc) begin
      r_derr   <= w_d_err;
      r_drdata <= (w_d_err || w_d_write) ? 32'd0
                                         : rd_extract(r_mem[w_d_idx], w_d_tsize, w_d_off);
    end
  end

  assign ibus_rdata = r_irdata;
  assign ibus_done  = w_i_done;
  assign ibus_err   = r_ierr;
  assign dbus_rdata = r_drdata;
  assign dbus_done  = w_d_done;
  assign dbus_err   = r_derr;

endmodule

// File: tb/tb_mem_wait_wrapped.sv
// Directed bench for mem_wait_wrapped (N=64, IWAIT=0, DWAIT=3).
module tb_mem_wait_wrapped;

  logic        clk;
  logic        rst;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic [31:0] ibus_rdata;
  logic        ibus_done;
  logic        ibus_err;
  logic        dbus_req;
  logic        dbus_write;
  logic [1:0]  dbus_tsize;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_done;
  logic        dbus_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_wait_wrapped #(.N(64), .IWAIT(0), .DWAIT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .ibus_req   (ibus_req),
    .ibus_addr  (ibus_addr),
    .ibus_rdata (ibus_rdata),
    .ibus_done  (ibus_done),
    .ibus_err   (ibus_err),
    .dbus_req   (dbus_req),
    .dbus_write (dbus_write),
    .dbus_tsize (dbus_tsize),
    .dbus_addr  (dbus_addr),
    .dbus_wdata (dbus_wdata),
    .dbus_rdata (dbus_rdata),
    .dbus_done  (dbus_done),
    .dbus_err   (dbus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One dbus transaction; fields are scrambled after capture to show they are held.
  task automatic dbus_xfer(input logic wr, input logic [1:0] ts, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic er, output int lat);
    dbus_req = 1'b1; dbus_write = wr; dbus_tsize = ts; dbus_addr = a; dbus_wdata = wd;
    lat = 0; rd = 32'd0; er = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      dbus_addr = ~a; dbus_wdata = ~wd; dbus_write = ~wr;
      if (dbus_done) begin
        lat = k; rd = dbus_rdata; er = dbus_err;
        break;
      end
    end
    dbus_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic ibus_xfer(input logic [31:0] a, output logic [31:0] rd,
                           output logic er, output int lat);
    ibus_req = 1'b1; ibus_addr = a;
    lat = 0; rd = 32'd0; er = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      ibus_addr = ~a;
      if (ibus_done) begin
        lat = k; rd = ibus_rdata; er = ibus_err;
        break;
      end
    end
    ibus_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          i_n, d_n, pulses, last_n, dpulses;
    logic [31:0] i_rd;

    rst = 1'b1; ibus_req = 1'b0; ibus_addr = 32'd0;
    dbus_req = 1'b0; dbus_write = 1'b0; dbus_tsize = 2'd0; dbus_addr = 32'd0; dbus_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ibus_done", 32'(ibus_done), 32'd0);
    check_val("rst_ibus_err", 32'(ibus_err), 32'd0);
    check_val("rst_ibus_rdata", ibus_rdata, 32'd0);
    check_val("rst_dbus_done", 32'(dbus_done), 32'd0);
    check_val("rst_dbus_err", 32'(dbus_err), 32'd0);
    check_val("rst_dbus_rdata", dbus_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // WORD write then read with three wait states.
    dbus_xfer(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check_val("wr10_lat", 32'(lat), 32'd5);
    check_val("wr10_err", 32'(er), 32'd0);
    dbus_xfer(1'b0, 2'd2, 32'h10, 32'h0, rd, er, lat);
    check_val("rd10_lat", 32'(lat), 32'd5);
    check_val("rd10_data", rd, 32'hDEADBEEF);
    check_val("rd10_err", 32'(er), 32'd0);

    // Byte write into lane 3, then word, byte and half reads.
    dbus_xfer(1'b1, 2'd2, 32'h10, 32'h11223344, rd, er, lat);
    dbus_xfer(1'b1, 2'd0, 32'h13, 32'h000000AB, rd, er, lat);
    check_val("wrb13_err", 32'(er), 32'd0);
    dbus_xfer(1'b0, 2'd2, 32'h10, 32'h0, rd, er, lat);
    check_val("rd10_after_byte", rd, 32'hAB223344);
    dbus_xfer(1'b0, 2'd0, 32'h13, 32'h0, rd, er, lat);
    check_val("rdb13", rd, 32'h000000AB);
    dbus_xfer(1'b0, 2'd1, 32'h12, 32'h0, rd, er, lat);
    check_val("rdh12", rd, 32'h0000AB22);

    // Error cases leave memory untouched.
    dbus_xfer(1'b1, 2'd2, 32'h20, 32'hA5A5A5A5, rd, er, lat);
    dbus_xfer(1'b1, 2'd2, 32'h00, 32'h01020304, rd, er, lat);
    dbus_xfer(1'b1, 2'd1, 32'h21, 32'h0000FFFF, rd, er, lat);
    check_val("e_half21_lat", 32'(lat), 32'd5);
    check_val("e_half21_err", 32'(er), 32'd1);
    check_val("e_half21_rdata", rd, 32'd0);
    dbus_xfer(1'b0, 2'd2, 32'h22, 32'h0, rd, er, lat);
    check_val("e_word22_err", 32'(er), 32'd1);
    check_val("e_word22_rdata", rd, 32'd0);
    dbus_xfer(1'b1, 2'd3, 32'h20, 32'h0, rd, er, lat);
    check_val("e_ts3_err", 32'(er), 32'd1);
    check_val("e_ts3_rdata", rd, 32'd0);
    dbus_xfer(1'b1, 2'd2, 32'h100, 32'h0BADF00D, rd, er, lat);
    check_val("e_oor_err", 32'(er), 32'd1);
    check_val("e_oor_rdata", rd, 32'd0);
    dbus_xfer(1'b0, 2'd2, 32'h20, 32'h0, rd, er, lat);
    check_val("e_mem20_kept", rd, 32'hA5A5A5A5);
    check_val("e_ok_err_clear", 32'(er), 32'd0);
    dbus_xfer(1'b0, 2'd2, 32'h00, 32'h0, rd, er, lat);
    check_val("e_mem00_kept", rd, 32'h01020304);
    ibus_xfer(32'h102, rd, er, lat);
    check_val("i_oor_err", 32'(er), 32'd1);
    check_val("i_oor_rdata", rd, 32'd0);

    // ibus read and dbus write of the same word completing on the same edge.
    dbus_xfer(1'b1, 2'd2, 32'h30, 32'hCAFEF00D, rd, er, lat);
    i_n = 0; d_n = 0; i_rd = 32'd0;
    dbus_req = 1'b1; dbus_write = 1'b1; dbus_tsize = 2'd2; dbus_addr = 32'h30; dbus_wdata = 32'h55;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 3) begin
        ibus_req = 1'b1; ibus_addr = 32'h30;
      end
      if (ibus_done && i_n == 0) begin
        i_n = n; i_rd = ibus_rdata; ibus_req = 1'b0;
      end
      if (dbus_done && d_n == 0) begin
        d_n = n; dbus_req = 1'b0;
      end
    end
    check_val("coll_ibus_n", 32'(i_n), 32'd5);
    check_val("coll_dbus_n", 32'(d_n), 32'd5);
    check_val("coll_ibus_old", i_rd, 32'hCAFEF00D);
    ibus_xfer(32'h30, rd, er, lat);
    check_val("coll_ibus_lat", 32'(lat), 32'd2);
    check_val("coll_ibus_new", rd, 32'h00000055);

    // Reset while a dbus write is waiting aborts it.
    dbus_xfer(1'b1, 2'd2, 32'h40, 32'h12345678, rd, er, lat);
    dbus_xfer(1'b0, 2'd2, 32'h10, 32'h0, rd, er, lat);
    dbus_req = 1'b1; dbus_write = 1'b1; dbus_tsize = 2'd2; dbus_addr = 32'h40; dbus_wdata = 32'h99999999;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; dbus_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mrst_dbus_rdata", dbus_rdata, 32'd0);
    check_val("mrst_ibus_rdata", ibus_rdata, 32'd0);
    check_val("mrst_dbus_err", 32'(dbus_err), 32'd0);
    dpulses = 0;
    for (int n = 0; n < 10; n++) begin
      if (dbus_done) dpulses++;
      @(posedge clk); #1;
    end
    check_val("mrst_no_done", 32'(dpulses), 32'd0);
    dbus_xfer(1'b0, 2'd2, 32'h40, 32'h0, rd, er, lat);
    check_val("mrst_mem_kept", rd, 32'h12345678);

    // ibus req held high: a done every third cycle, none lost or doubled.
    ibus_req = 1'b1; ibus_addr = 32'h10;
    pulses = 0; last_n = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (ibus_done) begin
        pulses++;
        if (pulses == 1) check_val("b2b_first", 32'(n), 32'd2);
        else check_val("b2b_gap", 32'(n - last_n), 32'd3);
        check_val("b2b_data", ibus_rdata, 32'hAB223344);
        last_n = n;
      end
    end
    ibus_req = 1'b0;
    check_val("b2b_pulses", 32'(pulses), 32'd10);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
